// File: rtl/debouncer_pkg.sv
// Shared defaults and counter-width helper for the debouncer slice.
// The optional rising-edge output of the top is controlled by DEBOUNCER_EDGE_EN.
package debouncer_pkg;

  // 0.5 ms sample period at 125 MHz, 100 ms total qualification time
  localparam int unsigned DEFAULT_SAMPLE_CNT_MAX = 62500;
  localparam int unsigned DEFAULT_PULSE_CNT_MAX  = 200;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debouncer_sample_pulse_gen.sv
// Free-running wrap counter producing one-cycle sample strobes every MAX+1 clocks.
// The strobe is a combinational compare on the counter register.
module sample_pulse_gen
  import debouncer_pkg::*;
#(
  parameter int unsigned MAX = DEFAULT_SAMPLE_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  output logic pulse
);

  localparam int unsigned W = cnt_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (cnt_q == MAX_V) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pulse = (cnt_q == MAX_V);

endmodule

// File: rtl/debouncer.sv
// Per-line debouncer: a bit asserts after PULSE_CNT_MAX consecutive high samples.
// Define DEBOUNCER_EDGE_EN to enable the rising_pulse output; otherwise it is tied low.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
  parameter int unsigned PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rising_pulse
);

  localparam int unsigned SW = cnt_width(PULSE_CNT_MAX);
  localparam logic [SW-1:0] PULSE_MAX_V = SW'(PULSE_CNT_MAX);

  logic             sample_pulse;
  logic [WIDTH-1:0] debounced;

  sample_pulse_gen #(
    .MAX (SAMPLE_CNT_MAX)
  ) u_sample_pulse_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (sample_pulse)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [SW-1:0] sat_q;
    logic [SW-1:0] sat_d;

    // A single low sample discards all progress; highs saturate at the threshold
    always_comb begin
      sat_d = sat_q;
      if (sample_pulse) begin
        if (!glitchy_signal[i])       sat_d = '0;
        else if (sat_q < PULSE_MAX_V) sat_d = sat_q + SW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_q <= '0;
      else        sat_q <= sat_d;
    end

    assign debounced[i] = (sat_q == PULSE_MAX_V);
  end

  assign debounced_signal = debounced;

`ifdef DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb prev_d = debounced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end

  assign rising_pulse = debounced & ~prev_q;
`else
  assign rising_pulse = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_debouncer.sv
// Directed self-checking bench for debouncer (WIDTH=2, sample every 5 cycles, 3 samples to assert).
// Rising-pulse expectations follow DEBOUNCER_EDGE_EN.
module tb_debouncer;

`ifdef DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] glitchy_signal;
  logic [1:0] debounced_signal;
  logic [1:0] rising_pulse;

  int checks;
  int fails;

  debouncer #(
    .WIDTH          (2),
    .SAMPLE_CNT_MAX (4),
    .PULSE_CNT_MAX  (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .glitchy_signal   (glitchy_signal),
    .debounced_signal (debounced_signal),
    .rising_pulse     (rising_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset for two cycles, release on a falling edge; afterwards we are in cycle 0
  task automatic do_reset(input logic [1:0] g);
    @(negedge clk);
    rst_n = 1'b0;
    glitchy_signal = g;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_rise;
    @(negedge clk);
    rst_n = 1'b0;
    glitchy_signal = 2'b11;
    step(3);
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_debounced: got %b expected 00", debounced_signal);
    end
    checks++;
    if (rising_pulse !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_rising: got %b expected 00", rising_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    glitchy_signal = 2'b00;
    step(3);
    checks++;
    if (dut.u_sample_pulse_gen.pulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pulse_cycle3: got %b expected 0", dut.u_sample_pulse_gen.pulse);
    end
    step(1);
    checks++;
    if (dut.u_sample_pulse_gen.pulse !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pulse_cycle4: got %b expected 1", dut.u_sample_pulse_gen.pulse);
    end
    step(1);
    checks++;
    if (dut.u_sample_pulse_gen.pulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pulse_cycle5: got %b expected 0", dut.u_sample_pulse_gen.pulse);
    end
    exp_rise = 2'b00;
    checks++;
    if (rising_pulse !== exp_rise) begin
      fails++;
      $display("[TB] FAIL reset_rising_idle: got %b expected %b", rising_pulse, exp_rise);
    end
  endtask

  task automatic test_hold();
    logic [1:0] exp_rise;
    do_reset(2'b01);
    step(14);
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL hold_cycle14: got %b expected 00", debounced_signal);
    end
    step(1);
    checks++;
    if (debounced_signal !== 2'b01) begin
      fails++;
      $display("[TB] FAIL hold_cycle15: got %b expected 01", debounced_signal);
    end
    exp_rise = EDGE_EN ? 2'b01 : 2'b00;
    checks++;
    if (rising_pulse !== exp_rise) begin
      fails++;
      $display("[TB] FAIL hold_rise15: got %b expected %b", rising_pulse, exp_rise);
    end
    step(1);
    checks++;
    if (rising_pulse !== 2'b00) begin
      fails++;
      $display("[TB] FAIL hold_rise16: got %b expected 00", rising_pulse);
    end
    checks++;
    if (debounced_signal !== 2'b01) begin
      fails++;
      $display("[TB] FAIL hold_cycle16: got %b expected 01", debounced_signal);
    end
  endtask

  task automatic test_glitch();
    do_reset(2'b01);
    step(10);
    glitchy_signal = 2'b00;
    step(5);
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL glitch_cycle15: got %b expected 00", debounced_signal);
    end
    glitchy_signal = 2'b01;
    step(14);
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL glitch_cycle29: got %b expected 00", debounced_signal);
    end
    step(1);
    checks++;
    if (debounced_signal !== 2'b01) begin
      fails++;
      $display("[TB] FAIL glitch_cycle30: got %b expected 01", debounced_signal);
    end
  endtask

  // Bit 1 toggles between samples but is high on every sampling edge
  task automatic test_noise();
    do_reset(2'b00);
    for (int c = 0; c < 15; c++) begin
      glitchy_signal[1] = ((c % 5) == 4) ? 1'b1 : c[0];
      if (c < 14) step(1);
    end
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL noise_cycle14: got %b expected 00", debounced_signal);
    end
    step(1);
    checks++;
    if (debounced_signal !== 2'b10) begin
      fails++;
      $display("[TB] FAIL noise_cycle15: got %b expected 10", debounced_signal);
    end
  endtask

  task automatic test_saturation();
    do_reset(2'b01);
    for (int k = 0; k < 3; k++) begin
      step(20 + (k == 0 ? 0 : -5));
      checks++;
      if (debounced_signal !== 2'b01) begin
        fails++;
        $display("[TB] FAIL sat_hold%0d: got %b expected 01", k, debounced_signal);
      end
    end
    checks++;
    if (rising_pulse !== 2'b00) begin
      fails++;
      $display("[TB] FAIL sat_rise_held: got %b expected 00", rising_pulse);
    end
    glitchy_signal = 2'b00;
    step(4);
    checks++;
    if (debounced_signal !== 2'b01) begin
      fails++;
      $display("[TB] FAIL sat_cycle54: got %b expected 01", debounced_signal);
    end
    step(1);
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL sat_cycle55: got %b expected 00", debounced_signal);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_rise;
    do_reset(2'b01);
    step(15);
    exp_rise = EDGE_EN ? 2'b01 : 2'b00;
    checks++;
    if (rising_pulse !== exp_rise) begin
      fails++;
      $display("[TB] FAIL mid_rise_first: got %b expected %b", rising_pulse, exp_rise);
    end
    do_reset(2'b01);
    step(12);
    rst_n = 1'b0;
    #1;
    checks++;
    if (debounced_signal !== 2'b00 || rising_pulse !== 2'b00) begin
      fails++;
      $display("[TB] FAIL mid_async_clear: got %b/%b expected 00/00", debounced_signal, rising_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL mid_cycle5: got %b expected 00", debounced_signal);
    end
    step(9);
    checks++;
    if (debounced_signal !== 2'b00) begin
      fails++;
      $display("[TB] FAIL mid_cycle14: got %b expected 00", debounced_signal);
    end
    step(1);
    checks++;
    if (debounced_signal !== 2'b01 || rising_pulse !== exp_rise) begin
      fails++;
      $display("[TB] FAIL mid_cycle15: got %b/%b expected 01/%b", debounced_signal, rising_pulse, exp_rise);
    end
    step(1);
    checks++;
    if (rising_pulse !== 2'b00) begin
      fails++;
      $display("[TB] FAIL mid_cycle16_rise: got %b expected 00", rising_pulse);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    glitchy_signal = 2'b00;
    test_reset();
    test_hold();
    test_glitch();
    test_noise();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
